// File: rtl/mode_ctrl_multi.sv
// mode_ctrl_multi: mode FSM that sequences multi-channel init with settle timing,
// retries and fault capture; all outputs registered alongside the state.
module mode_ctrl_multi #(
   parameter int N_INIT         = 4,
   parameter int TD_MODE_CHANGE = 100,
   parameter int TO_INIT        = 1000,
   parameter int MAX_RETRY      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        im_mode_byte,
   input  logic              i_rst_req,
   input  logic [N_INIT-1:0] im_ini_done,
   input  logic [N_INIT-1:0] im_ini_fail,
   output logic [N_INIT-1:0] om_ini_start,
   output logic [2:0]        om_mode_reg,
   output logic              o_tb_txen,
   output logic              o_mb_txen,
   output logic              o_down_en,
   output logic              o_fault,
   output logic [N_INIT-1:0] om_fail_map
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DOWN   = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd4;
   localparam logic [2:0] S_CON    = 3'd5;
   localparam logic [2:0] S_FAULT  = 3'd6;
   localparam int CW = $clog2(TO_INIT + 1);
   logic [2:0]        state, nxt, retries, retries_nxt, mode_nxt;
   logic [CW-1:0]     cnt, cnt_inc;
   logic [N_INIT-1:0] sticky, fail_map_nxt;
   logic              c_run, c_con, c_down, all_done, fail_ev, run_ok, can_retry;
   assign c_run     = im_mode_byte == 8'h00;
   assign c_con     = im_mode_byte == 8'h01;
   assign c_down    = im_mode_byte == 8'h02;
   assign all_done  = &sticky;
   // decisions use the post-increment count so SETTLE lasts exactly TD_MODE_CHANGE cycles minimum
   assign cnt_inc   = (cnt == CW'(TO_INIT)) ? cnt : cnt + CW'(1);
   assign fail_ev   = (|im_ini_fail) || (cnt_inc == CW'(TO_INIT) && !all_done);
   assign run_ok    = (cnt_inc >= CW'(TD_MODE_CHANGE)) && all_done;
   assign can_retry = retries < 3'(MAX_RETRY);
   always_comb begin
      nxt          = state;
      retries_nxt  = retries;
      fail_map_nxt = om_fail_map;
      case (state)
         S_IDLE:  nxt = c_down ? S_DOWN : S_IDLE;
         S_DOWN:  if (c_run || i_rst_req) begin
            nxt         = S_START;
            retries_nxt = '0;
         end
         S_START: nxt = S_SETTLE;
         S_SETTLE: if (fail_ev) begin
            fail_map_nxt = (|im_ini_fail) ? im_ini_fail : ~sticky;
            nxt          = can_retry ? S_START : S_FAULT;
            retries_nxt  = can_retry ? retries + 3'd1 : retries;
         end else if (run_ok) begin
            nxt          = S_RUN;
            fail_map_nxt = '0;
         end
         S_RUN: if (c_down) nxt = S_DOWN;
         else if (i_rst_req) begin
            nxt         = S_START;
            retries_nxt = '0;
         end else if (c_con) nxt = S_CON;
         S_CON: if (c_down) nxt = S_DOWN;
         else if (i_rst_req) begin
            nxt         = S_START;
            retries_nxt = '0;
         end else if (c_run) nxt = S_RUN;
         S_FAULT: if (c_down) begin
            nxt          = S_DOWN;
            fail_map_nxt = '0;
         end
         default: nxt = S_IDLE;
      endcase
   end
   always_comb
      mode_nxt = (nxt == S_DOWN)                        ? 3'b100 :
                 (nxt == S_START || nxt == S_SETTLE)    ? 3'b111 :
                 (nxt == S_RUN)                         ? 3'b001 :
                 (nxt == S_CON)                         ? 3'b010 :
                 (nxt == S_FAULT)                       ? 3'b110 : 3'b000;
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         retries      <= '0;
         cnt          <= '0;
         sticky       <= '0;
         om_mode_reg  <= 3'b000;
         om_ini_start <= '0;
         om_fail_map  <= '0;
         o_tb_txen    <= 1'b0;
         o_mb_txen    <= 1'b1;
         o_down_en    <= 1'b0;
         o_fault      <= 1'b0;
      end else begin
         state        <= nxt;
         retries      <= retries_nxt;
         cnt          <= (state == S_START) ? '0 : (state == S_SETTLE) ? cnt_inc : cnt;
         sticky       <= (state == S_START) ? '0 : (state == S_SETTLE) ? sticky | im_ini_done : sticky;
         om_mode_reg  <= mode_nxt;
         om_ini_start <= {N_INIT{nxt == S_START}};
         om_fail_map  <= fail_map_nxt;
         o_tb_txen    <= nxt == S_RUN || nxt == S_CON;
         o_mb_txen    <= 1'b1;
         o_down_en    <= nxt == S_DOWN;
         o_fault      <= nxt == S_FAULT;
      end
   end
endmodule

// File: tb/tb_mode_ctrl_multi.sv
// tb_mode_ctrl_multi: directed bench for mode_ctrl_multi at default parameters
// (N_INIT=4, TD=100, TO=1000, MAX_RETRY=2) with hand-computed expectations.
module tb_mode_ctrl_multi;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] im_mode_byte = 8'h55;
   logic       i_rst_req = 1'b0;
   logic [3:0] im_ini_done = '0, im_ini_fail = '0;
   logic [3:0] om_ini_start, om_fail_map;
   logic [2:0] om_mode_reg;
   logic       o_tb_txen, o_mb_txen, o_down_en, o_fault;
   int         n_checks = 0, n_fail = 0;

   mode_ctrl_multi dut (
      .clk(clk), .rst(rst), .im_mode_byte(im_mode_byte), .i_rst_req(i_rst_req),
      .im_ini_done(im_ini_done), .im_ini_fail(im_ini_fail), .om_ini_start(om_ini_start),
      .om_mode_reg(om_mode_reg), .o_tb_txen(o_tb_txen), .o_mb_txen(o_mb_txen),
      .o_down_en(o_down_en), .o_fault(o_fault), .om_fail_map(om_fail_map)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_mode"}, 32'(om_mode_reg), 32'b000);
      check({tag, "_start"}, 32'(om_ini_start), 32'h0);
      check({tag, "_tb"}, 32'(o_tb_txen), 32'd0);
      check({tag, "_mb"}, 32'(o_mb_txen), 32'd1);
      check({tag, "_down"}, 32'(o_down_en), 32'd0);
      check({tag, "_fault"}, 32'(o_fault), 32'd0);
      check({tag, "_map"}, 32'(om_fail_map), 32'h0);
   endtask

   initial begin
      step(2);
      check_reset_vals("rst");
      rst = 1'b0;
      // IDLE ignores run command and restart request
      im_mode_byte = 8'h00; i_rst_req = 1'b1; step(1);
      check("idle_ignore", 32'(om_mode_reg), 32'b000);
      i_rst_req = 1'b0; im_mode_byte = 8'h02; step(1);
      check("down_mode", 32'(om_mode_reg), 32'b100);
      check("down_en", 32'(o_down_en), 32'd1);
      check("down_tb", 32'(o_tb_txen), 32'd0);
      // settle timing: START, then RUN exactly 101 edges after START
      im_mode_byte = 8'h00; step(1);
      im_mode_byte = 8'h55;
      check("start_pulse", 32'(om_ini_start), 32'hF);
      check("start_mode", 32'(om_mode_reg), 32'b111);
      step(1);
      check("settle_start", 32'(om_ini_start), 32'h0);
      check("settle_down", 32'(o_down_en), 32'd0);
      im_ini_done = 4'hF; step(1); im_ini_done = 4'h0;
      step(98);
      check("settle_not_early", 32'(om_mode_reg), 32'b111);
      step(1);
      check("run_mode", 32'(om_mode_reg), 32'b001);
      check("run_tb", 32'(o_tb_txen), 32'd1);
      check("run_mb", 32'(o_mb_txen), 32'd1);
      // RUN/CON transitions and DOWN priority over restart
      im_mode_byte = 8'h01; step(1);
      check("con_mode", 32'(om_mode_reg), 32'b010);
      im_mode_byte = 8'h00; step(1);
      check("con_to_run", 32'(om_mode_reg), 32'b001);
      im_mode_byte = 8'h02; i_rst_req = 1'b1; step(1);
      check("run_down_prio", 32'(om_mode_reg), 32'b100);
      check("run_down_start", 32'(om_ini_start), 32'h0);
      im_mode_byte = 8'h55;
      // repeated channel-2 failure exhausts two retries
      step(1);
      i_rst_req = 1'b0;
      check("req_start", 32'(om_ini_start), 32'hF);
      for (int i = 0; i < 2; i++) begin
         step(1);
         im_ini_fail = 4'b0100; step(1); im_ini_fail = 4'h0;
         check($sformatf("retry%0d_start", i), 32'(om_ini_start), 32'hF);
         check($sformatf("retry%0d_map", i), 32'(om_fail_map), 32'h4);
      end
      step(1);
      im_ini_fail = 4'b0100; step(1); im_ini_fail = 4'h0;
      check("fault_mode", 32'(om_mode_reg), 32'b110);
      check("fault_flag", 32'(o_fault), 32'd1);
      check("fault_map", 32'(om_fail_map), 32'h4);
      check("fault_start", 32'(om_ini_start), 32'h0);
      check("fault_tb", 32'(o_tb_txen), 32'd0);
      im_mode_byte = 8'h00; i_rst_req = 1'b1; step(1);
      i_rst_req = 1'b0;
      check("fault_hold", 32'(om_mode_reg), 32'b110);
      im_mode_byte = 8'h02; step(1);
      check("fault_exit_mode", 32'(om_mode_reg), 32'b100);
      check("fault_exit_flag", 32'(o_fault), 32'd0);
      check("fault_exit_map", 32'(om_fail_map), 32'h0);
      // all done with a fail in the RUN-eligible cycle: failure wins
      im_mode_byte = 8'h00; step(1); im_mode_byte = 8'h55;
      step(1);
      im_ini_done = 4'hF; step(1); im_ini_done = 4'h0;
      step(98);
      im_ini_fail = 4'b0001; step(1); im_ini_fail = 4'h0;
      check("same_cycle_mode", 32'(om_mode_reg), 32'b111);
      check("same_cycle_start", 32'(om_ini_start), 32'hF);
      check("same_cycle_map", 32'(om_fail_map), 32'h1);
      // channel 3 never done: two timeouts of 1000 settle cycles (retry 1 already used)
      im_ini_done = 4'b0111;
      step(1000);
      check("to1_not_early", 32'(om_ini_start), 32'h0);
      step(1);
      check("to1_restart", 32'(om_ini_start), 32'hF);
      check("to1_map", 32'(om_fail_map), 32'h8);
      step(1000);
      check("to2_not_early", 32'(om_mode_reg), 32'b111);
      step(1);
      check("to2_fault", 32'(om_mode_reg), 32'b110);
      check("to2_flag", 32'(o_fault), 32'd1);
      check("to2_map", 32'(om_fail_map), 32'h8);
      im_ini_done = 4'h0;
      im_mode_byte = 8'h02; step(1);
      check("to_exit_map", 32'(om_fail_map), 32'h0);
      // reset in the middle of SETTLE
      im_mode_byte = 8'h00; step(1); im_mode_byte = 8'h55;
      step(5);
      rst = 1'b1; step(1); rst = 1'b0;
      check_reset_vals("mid_rst");
      step(3);
      check("post_rst_start", 32'(om_ini_start), 32'h0);
      check("post_rst_mode", 32'(om_mode_reg), 32'b000);
      // a later successful RUN entry clears a held fail map
      im_mode_byte = 8'h02; step(1);
      im_mode_byte = 8'h00; step(1); im_mode_byte = 8'h55;
      step(1);
      im_ini_fail = 4'b0010; step(1); im_ini_fail = 4'h0;
      check("hold_map", 32'(om_fail_map), 32'h2);
      step(1);
      im_ini_done = 4'hF; step(1); im_ini_done = 4'h0;
      step(98);
      check("hold_map_settle", 32'(om_fail_map), 32'h2);
      step(1);
      check("clear_run_mode", 32'(om_mode_reg), 32'b001);
      check("clear_run_map", 32'(om_fail_map), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
